keypad_scan_v: RTL and testbench

KEYPAD_SCAN_V -- requirements
Module: keypad_scan_v

---
 rtl/micro_pkg_v.sv | 11 +
 rtl/sync_2ff_v.sv | 21 ++
 rtl/keypad_scan_v.sv | 103 ++++++++++
 tb/tb_keypad_scan_v.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/micro_pkg_v.sv
// micro_pkg_v: shared keypad dimensions, code width, scan FSM states and row priority helper
package micro_pkg_v;
  localparam int CODE_W = 4;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  typedef enum logic [2:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_HOLD, S_RELEASE} kp_state_e;
  function automatic logic [1:0] lowest_low(input logic [ROWS-1:0] rows);
    lowest_low = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) if (!rows[i]) lowest_low = 2'(i);
  endfunction
endpackage

// File: rtl/sync_2ff_v.sv
// sync_2ff_v: two-flop synchronizer for active-low rows, resets to idle (all ones)
module sync_2ff_v #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] s1_q, s2_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= i_d;
      s2_q <= s1_q;
    end
  end
  assign o_q = s2_q;
endmodule

// File: rtl/keypad_scan_v.sv
// keypad_scan_v: 4x4 column-scan keypad with press/release debounce and a single strobe per key
module keypad_scan_v
  import micro_pkg_v::*;
#(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ROWS-1:0]   i_row,
  output logic [COLS-1:0]   o_col,
  output logic              o_en,
  output logic [CODE_W-1:0] o_code
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  kp_state_e         state_q, state_d;
  logic [1:0]        col_q, col_d, row_q, row_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [DW-1:0]     cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [ROWS-1:0]   row_s;
  logic              key_low, any_low;
  sync_2ff_v #(.W(ROWS)) u_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_row),
    .o_q    (row_s)
  );
  assign key_low = !row_s[row_q];
  assign any_low = row_s != '1;
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    en_d     = 1'b0;
    code_d   = code_q;
    case (state_q)
      S_SCAN: begin
        settle_d = (settle_q == SETTLE_LAST) ? '0 : settle_q + 1'b1;
        if (settle_q == SETTLE_LAST) begin
          if (any_low) begin
            row_d   = lowest_low(row_s);
            cnt_d   = '0;
            state_d = S_DEBOUNCE;
          end else col_d = col_q + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (!key_low) begin
          state_d = S_SCAN;
          col_d   = col_q + 1'b1;
        end else if (cnt_q == DB_LAST) begin
          state_d = S_EMIT;
          en_d    = 1'b1;
          code_d  = {row_q, col_q};
        end else cnt_d = cnt_q + 1'b1;
      end
      S_EMIT: state_d = S_HOLD;
      S_HOLD: begin
        if (!key_low) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (key_low) state_d = S_HOLD;
        else if (cnt_q == DB_LAST) begin
          state_d = S_SCAN;
          col_d   = col_q + 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_SCAN;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_SCAN;
      col_q    <= '0;
      row_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      code_q   <= code_d;
    end
  end
  assign o_col  = ~(COLS'(1) << col_q);
  assign o_en   = en_q;
  assign o_code = code_q;
endmodule

// File: tb/tb_keypad_scan_v.sv
// tb_keypad_scan_v: directed checks of scan order, debounce, single strobe, bounce and reset
module tb_keypad_scan_v;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row = 4'hF;
  logic [3:0] col;
  logic       en;
  logic [3:0] code;
  int         checks = 0;
  int         fails = 0;
  int         en_cnt = 0;
  int         dbl = 0;
  int         b;
  logic       prev_en = 1'b0;
  logic [3:0] last_code = 4'h0;
  logic [3:0] e;

  always #5 clk = ~clk;

  keypad_scan_v #(.SETTLE_CYCLES(4), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_row  (row),
    .o_col  (col),
    .o_en   (en),
    .o_code (code)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (en) begin
        en_cnt++;
        last_code = code;
        if (prev_en) dbl++;
      end
      prev_en = en;
    end else prev_en = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input string tag, input logic [3:0] pat, input int budget);
    logic [3:0] p;
    bit hit;
    p = col;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      step(1);
      hit = (col == pat) && (p != pat);
      p = col;
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_en(input string tag, input int budget);
    int base;
    base = en_cnt;
    for (int i = 0; i < budget && en_cnt == base; i++) step(1);
    check(tag, 32'(en_cnt > base), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_col", 32'(col), 32'hE);
    check("rst_en", 32'(en), 32'h0);
    check("rst_code", 32'(code), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      step(1);
      e = ~(4'b0001 << ((k / 4) % 4));
      check("idle_col", 32'(col), 32'(e));
    end
    check("idle_no_en", 32'(en_cnt), 32'd0);

    wait_col("r25_col0", 4'b1110, 20);
    row = 4'b1011;
    step(7);
    check("r25_en_early", 32'(en), 32'h0);
    step(1);
    check("r25_en", 32'(en), 32'h1);
    check("r25_code", 32'(code), 32'h8);
    step(1);
    check("r25_en_once", 32'(en), 32'h0);
    step(38);
    check("r25_hold_col", 32'(col), 32'hE);
    check("r25_count", 32'(en_cnt), 32'd1);
    row = 4'hF;
    step(3);
    check("r25_rel_col", 32'(col), 32'hE);
    wait_col("r25_next_col", 4'b1101, 12);

    wait_col("r26_col3", 4'b0111, 20);
    b = en_cnt;
    step(1);
    row = 4'b1101;
    step(2);
    row = 4'hF;
    step(2);
    check("r26_deb_col", 32'(col), 32'h7);
    step(1);
    check("r26_resume", 32'(col), 32'hE);
    step(10);
    check("r26_no_en", 32'(en_cnt), 32'(b));

    wait_col("r27_col3", 4'b0111, 20);
    b = en_cnt;
    row = 4'b0111;
    wait_en("r27_en", 23);
    check("r27_code", 32'(last_code), 32'hF);
    step(20);
    check("r27_one", 32'(en_cnt), 32'(b + 1));
    row = 4'hF;
    step(3);
    row = 4'b0111;
    step(1);
    row = 4'hF;
    step(4);
    check("r27_bounce_col", 32'(col), 32'h7);
    wait_col("r27_resume", 4'b1110, 10);
    check("r27_still_one", 32'(en_cnt), 32'(b + 1));

    wait_col("r28_col1", 4'b1101, 20);
    b = en_cnt;
    row = 4'b1010;
    wait_en("r28_en", 23);
    check("r28_code", 32'(last_code), 32'h1);
    step(10);
    check("r28_one", 32'(en_cnt), 32'(b + 1));
    check("r28_hold_col", 32'(col), 32'hD);
    row = 4'hF;
    wait_col("r28_next_col", 4'b1011, 12);

    wait_col("r29_col1", 4'b1101, 20);
    b = en_cnt;
    row = 4'b1110;
    step(5);
    check("r29_deb_col", 32'(col), 32'hD);
    rst_n = 1'b0;
    #1;
    check("r29_rst_col", 32'(col), 32'hE);
    check("r29_rst_en", 32'(en), 32'h0);
    check("r29_rst_code", 32'(code), 32'h0);
    check("r29_no_early", 32'(en_cnt), 32'(b));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b = en_cnt;
    wait_en("r29_en", 23);
    check("r29_code", 32'(last_code), 32'h0);
    step(20);
    check("r29_one", 32'(en_cnt), 32'(b + 1));

    check("no_back_to_back", 32'(dbl), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
